alu_exec_unit: RTL and testbench

//  Execute-stage ALU with the ALU-control decode built in. Decodes alu_op/funct3/funct7[5] and computes the result.

---
 rtl/alu_exec_unit_if.sv | 50 +++++
 rtl/alu_exec_unit.sv | 189 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Purpose : Bundles the operation handshake, operand bus and result/flag
//           outputs of alu_exec_unit.
// Signals : i_valid/o_ready     op handshake (upstream -> unit)
//           i_alu_op/i_funct3/i_funct7b5/i_op1/i_op2   operation and operands
//           o_valid/i_ready     result handshake (unit -> downstream)
//           o_result/o_eq/o_lt/o_ltu                   result and compare flags
//           o_illegal           present only when ALU_EXEC_ILLEGAL_EN is defined
// Modports: slave  - the execution unit
//           master - the driver of operations / consumer of results
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [1:0]      i_alu_op;
    logic [2:0]      i_funct3;
    logic            i_funct7b5;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_eq;
    logic            o_lt;
    logic            o_ltu;
`ifdef ALU_EXEC_ILLEGAL_EN
    logic            o_illegal;

    modport slave (
        input  i_valid, i_alu_op, i_funct3, i_funct7b5, i_op1, i_op2, i_ready,
        output o_ready, o_valid, o_result, o_eq, o_lt, o_ltu, o_illegal
    );
    modport master (
        output i_valid, i_alu_op, i_funct3, i_funct7b5, i_op1, i_op2, i_ready,
        input  o_ready, o_valid, o_result, o_eq, o_lt, o_ltu, o_illegal
    );
`else
    modport slave (
        input  i_valid, i_alu_op, i_funct3, i_funct7b5, i_op1, i_op2, i_ready,
        output o_ready, o_valid, o_result, o_eq, o_lt, o_ltu
    );
    modport master (
        output i_valid, i_alu_op, i_funct3, i_funct7b5, i_op1, i_op2, i_ready,
        input  o_ready, o_valid, o_result, o_eq, o_lt, o_ltu
    );
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Purpose : Execute-stage ALU with built-in ALU-control decode. Accepts an op
//           over a valid/ready handshake, computes the result (shifts run
//           serially, SHIFT_STEP bits per cycle) and presents a registered
//           result plus branch-compare flags over a second valid/ready pair.
// Ports   : i_clk  clock, all state on the rising edge
//           i_rst  asynchronous active-high reset
//           bus    alu_exec_unit_if.slave (op handshake, operands, result, flags)
// Params  : XLEN (power of two, >= 8), SHIFT_STEP (power of two, 1..XLEN)
// Option  : ALU_EXEC_ILLEGAL_EN - when defined, bus.o_illegal flags illegal
//           encodings; otherwise they silently return 0.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_exec_unit_if.slave bus
);
    localparam int              SH_W   = $clog2(XLEN);
    // One extra bit so SHIFT_STEP == XLEN is representable.
    localparam logic [SH_W:0]   STEP_C = (SH_W+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR,  OP_AND, OP_PASSB, OP_ILL
    } op_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [SH_W-1:0]   rem_q, rem_d;
    op_t               shop_q, shop_d;
    logic              eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
`ifdef ALU_EXEC_ILLEGAL_EN
    logic              illegal_q, illegal_d;
`endif

    op_t               op_dec;
    logic [XLEN-1:0]   alu_val;
    logic [SH_W-1:0]   shamt;
    logic              is_shift;
    logic              ready;
    logic              accept;
    logic [SH_W:0]     rem_ext;
    logic [SH_W:0]     step_amt;
    logic [XLEN-1:0]   shifted;

    assign shamt  = bus.i_op2[SH_W-1:0];
    assign ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.i_ready);
    assign accept = bus.i_valid & ready;

    // ALU-control decode and the single-cycle datapath.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned and infers a latch.
        op_dec  = OP_ILL;
        alu_val = '0;
        case (bus.i_alu_op)
            2'b00, 2'b01: begin
                // R-type rejects funct7b5=1 except on ADD/SUB and SRL/SRA;
                // I-type ignores it except to pick SRLI/SRAI.
                case (bus.i_funct3)
                    3'b000: op_dec = (bus.i_alu_op == 2'b00 && bus.i_funct7b5) ? OP_SUB : OP_ADD;
                    3'b001: op_dec = OP_SLL;
                    3'b010: op_dec = OP_SLT;
                    3'b011: op_dec = OP_SLTU;
                    3'b100: op_dec = OP_XOR;
                    3'b101: op_dec = bus.i_funct7b5 ? OP_SRA : OP_SRL;
                    3'b110: op_dec = OP_OR;
                    default: op_dec = OP_AND;
                endcase
                if (bus.i_alu_op == 2'b00 && bus.i_funct7b5 &&
                    bus.i_funct3 != 3'b000 && bus.i_funct3 != 3'b101) begin
                    op_dec = OP_ILL;
                end
            end
            2'b10:   op_dec = OP_PASSB;
            default: op_dec = OP_ADD;
        endcase

        case (op_dec)
            OP_ADD:   alu_val = bus.i_op1 + bus.i_op2;
            OP_SUB:   alu_val = bus.i_op1 - bus.i_op2;
            OP_SLT:   alu_val = {{(XLEN-1){1'b0}}, $signed(bus.i_op1) < $signed(bus.i_op2)};
            OP_SLTU:  alu_val = {{(XLEN-1){1'b0}}, bus.i_op1 < bus.i_op2};
            OP_XOR:   alu_val = bus.i_op1 ^ bus.i_op2;
            OP_OR:    alu_val = bus.i_op1 | bus.i_op2;
            OP_AND:   alu_val = bus.i_op1 & bus.i_op2;
            OP_PASSB: alu_val = bus.i_op2;
            // Shifts preload op1; a zero shamt finishes with it unchanged.
            OP_SLL, OP_SRL, OP_SRA: alu_val = bus.i_op1;
            default:  alu_val = '0;
        endcase
    end

    assign is_shift = (op_dec == OP_SLL) || (op_dec == OP_SRL) || (op_dec == OP_SRA);

    // One serial shift step of min(SHIFT_STEP, remaining) bits. The SRA fill
    // is the register MSB, which still holds the captured op1 sign.
    assign rem_ext  = {1'b0, rem_q};
    assign step_amt = (rem_ext <= STEP_C) ? rem_ext : STEP_C;

    always_comb begin
        shifted = result_q >> step_amt;
        case (shop_q)
            OP_SLL:  shifted = result_q << step_amt;
            OP_SRA:  shifted = $signed(result_q) >>> step_amt;
            default: shifted = result_q >> step_amt;
        endcase
    end

    // Next-state logic; an accepted op overrides the hold/return-to-idle path.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        rem_d     = rem_q;
        shop_d    = shop_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        ltu_d     = ltu_q;
`ifdef ALU_EXEC_ILLEGAL_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_SHIFT: begin
                result_d = shifted;
                rem_d    = rem_q - step_amt[SH_W-1:0];
                if (rem_ext <= STEP_C) state_d = ST_DONE;
            end
            ST_DONE:  if (bus.i_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            result_d = alu_val;
            rem_d    = shamt;
            shop_d   = op_dec;
            eq_d     = (bus.i_op1 == bus.i_op2);
            lt_d     = ($signed(bus.i_op1) < $signed(bus.i_op2));
            ltu_d    = (bus.i_op1 < bus.i_op2);
            state_d  = (is_shift && shamt != '0) ? ST_SHIFT : ST_DONE;
`ifdef ALU_EXEC_ILLEGAL_EN
            illegal_d = (op_dec == OP_ILL);
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            rem_q     <= '0;
            shop_q    <= OP_ADD;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            ltu_q     <= 1'b0;
`ifdef ALU_EXEC_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
            state_q   <= state_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            shop_q    <= shop_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            ltu_q     <= ltu_d;
`ifdef ALU_EXEC_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_valid  = (state_q == ST_DONE);
    assign bus.o_result = result_q;
    assign bus.o_eq     = eq_q;
    assign bus.o_lt     = lt_q;
    assign bus.o_ltu    = ltu_q;
`ifdef ALU_EXEC_ILLEGAL_EN
    assign bus.o_illegal = illegal_q & (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed test of alu_exec_unit (XLEN=32, SHIFT_STEP=4) with hand-computed
// expected results, latencies and flags; also covers backpressure,
// back-to-back accept, and reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    alu_exec_unit_if #(.XLEN(XLEN)) bus_if ();

    alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        ill;
    } vec_t;

    vec_t vecs[19];

    task automatic drive_op(input vec_t v);
        bus_if.i_alu_op   = v.op;
        bus_if.i_funct3   = v.f3;
        bus_if.i_funct7b5 = v.f7;
        bus_if.i_op1      = v.a;
        bus_if.i_op2      = v.b;
        bus_if.i_valid    = 1'b1;
    endtask

    // Issue one op with the result side always ready; measure latency and
    // the number of cycles o_ready stays low before the result appears.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int busy;
        @(negedge i_clk);
        drive_op(v);
        check($sformatf("v%0d_ready_in", idx), {31'd0, bus_if.o_ready}, 32'd1);
        @(posedge i_clk);
        #1 bus_if.i_valid = 1'b0;
        lat  = 1;
        busy = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge i_clk);
            if (bus_if.o_valid) break;
            if (!bus_if.o_ready) busy++;
            lat++;
        end
        check($sformatf("v%0d_lat", idx),  32'(lat), 32'(v.lat));
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.lat - 1));
        check($sformatf("v%0d_res", idx),  bus_if.o_result, v.res);
        check($sformatf("v%0d_eq", idx),   {31'd0, bus_if.o_eq},  {31'd0, v.eq});
        check($sformatf("v%0d_lt", idx),   {31'd0, bus_if.o_lt},  {31'd0, v.lt});
        check($sformatf("v%0d_ltu", idx),  {31'd0, bus_if.o_ltu}, {31'd0, v.ltu});
`ifdef ALU_EXEC_ILLEGAL_EN
        check($sformatf("v%0d_ill", idx),  {31'd0, bus_if.o_illegal}, {31'd0, v.ill});
`endif
    endtask

    initial begin
        //            op     f3     f7    op1           op2           result        lat eq lt ltu ill
        vecs[0]  = '{2'b00, 3'b000, 1'b0, 32'd5,        32'd7,        32'd12,       1, 0, 1, 1, 0}; // ADD
        vecs[1]  = '{2'b00, 3'b000, 1'b1, 32'd3,        32'd5,        32'hFFFFFFFE, 1, 0, 1, 1, 0}; // SUB
        vecs[2]  = '{2'b00, 3'b011, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd1,        1, 0, 0, 1, 0}; // SLTU
        vecs[3]  = '{2'b00, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1, 0, 1, 0, 0}; // SLT
        vecs[4]  = '{2'b00, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0, 1, 1, 0}; // XOR
        vecs[5]  = '{2'b00, 3'b110, 1'b0, 32'h0F,       32'hF0,       32'hFF,       1, 0, 1, 1, 0}; // OR
        vecs[6]  = '{2'b00, 3'b111, 1'b0, 32'hFF,       32'h0F,       32'h0F,       1, 0, 0, 0, 0}; // AND
        vecs[7]  = '{2'b00, 3'b001, 1'b0, 32'd1,        32'd4,        32'h10,       2, 0, 1, 1, 0}; // SLL 4
        vecs[8]  = '{2'b00, 3'b101, 1'b0, 32'h80000000, 32'd31,       32'd1,        9, 0, 1, 0, 0}; // SRL 31
        vecs[9]  = '{2'b01, 3'b101, 1'b1, 32'h80000000, 32'd31,       32'hFFFFFFFF, 9, 0, 1, 0, 0}; // SRAI 31
        vecs[10] = '{2'b01, 3'b101, 1'b1, 32'h80000000, 32'd0,        32'h80000000, 1, 0, 1, 0, 0}; // SRAI 0
        vecs[11] = '{2'b01, 3'b000, 1'b1, 32'd10,       32'hFFFFFFFF, 32'd9,        1, 0, 0, 1, 0}; // ADDI
        vecs[12] = '{2'b01, 3'b001, 1'b1, 32'd3,        32'd5,        32'h60,       3, 0, 1, 1, 0}; // SLLI 5
        vecs[13] = '{2'b10, 3'b111, 1'b1, 32'd0,        32'h12345000, 32'h12345000, 1, 0, 1, 1, 0}; // PASS_B
        vecs[14] = '{2'b11, 3'b101, 1'b1, 32'h1000,     32'h24,       32'h1024,     1, 0, 0, 0, 0}; // ADD addr
        vecs[15] = '{2'b00, 3'b111, 1'b1, 32'h1234,     32'h1234,     32'd0,        1, 1, 0, 0, 1}; // illegal
        vecs[16] = '{2'b00, 3'b001, 1'b1, 32'd5,        32'd3,        32'd0,        1, 0, 0, 0, 1}; // illegal
        vecs[17] = '{2'b00, 3'b101, 1'b1, 32'hF0000000, 32'd6,        32'hFFC00000, 3, 0, 1, 0, 0}; // SRA 6
        vecs[18] = '{2'b00, 3'b101, 1'b0, 32'hF0,       32'd5,        32'd7,        3, 0, 0, 0, 0}; // SRL 5

        bus_if.i_valid    = 1'b0;
        bus_if.i_ready    = 1'b1;
        bus_if.i_alu_op   = 2'b00;
        bus_if.i_funct3   = 3'b000;
        bus_if.i_funct7b5 = 1'b0;
        bus_if.i_op1      = '0;
        bus_if.i_op2      = '0;

        // Reset state.
        repeat (2) @(negedge i_clk);
        check("rst_valid",  {31'd0, bus_if.o_valid}, 32'd0);
        check("rst_result", bus_if.o_result, 32'd0);
        check("rst_flags",  {29'd0, bus_if.o_eq, bus_if.o_lt, bus_if.o_ltu}, 32'd0);
`ifdef ALU_EXEC_ILLEGAL_EN
        check("rst_ill",    {31'd0, bus_if.o_illegal}, 32'd0);
`endif
        i_rst = 1'b0;
        #1 check("rst_ready", {31'd0, bus_if.o_ready}, 32'd1);

        for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

        // Backpressure, then back-to-back accept of the pending op.
        @(negedge i_clk);
        bus_if.i_ready = 1'b0;
        drive_op(vecs[0]);
        @(posedge i_clk);
        #1 drive_op(vecs[1]);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check($sformatf("bp%0d_valid", c), {31'd0, bus_if.o_valid}, 32'd1);
            check($sformatf("bp%0d_res", c),   bus_if.o_result, 32'd12);
            check($sformatf("bp%0d_flags", c), {29'd0, bus_if.o_eq, bus_if.o_lt, bus_if.o_ltu}, 32'b011);
            check($sformatf("bp%0d_ready", c), {31'd0, bus_if.o_ready}, 32'd0);
        end
        @(negedge i_clk);
        bus_if.i_ready = 1'b1;
        #1 check("b2b_ready", {31'd0, bus_if.o_ready}, 32'd1);
        @(posedge i_clk);
        #1 bus_if.i_valid = 1'b0;
        @(negedge i_clk);
        check("b2b_valid", {31'd0, bus_if.o_valid}, 32'd1);
        check("b2b_res",   bus_if.o_result, 32'hFFFFFFFE);

        // Reset in the middle of a shift.
        @(negedge i_clk);
        drive_op(vecs[9]);
        @(posedge i_clk);
        #1 bus_if.i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("mid_ready", {31'd0, bus_if.o_ready}, 32'd0);
        check("mid_valid", {31'd0, bus_if.o_valid}, 32'd0);
        i_rst = 1'b1;
        #1;
        check("arst_valid",  {31'd0, bus_if.o_valid}, 32'd0);
        check("arst_result", bus_if.o_result, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("arst_ready", {31'd0, bus_if.o_ready}, 32'd1);
        check("arst_idle",  {31'd0, bus_if.o_valid}, 32'd0);
        run_vec(vecs[17], 100);

        @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
